// File: rtl/amp_mod_pkg.sv
// Shared types and the saturating clamp for the amp_modulator_mc datapath.
// The clamp works on a wide signed value so any lane width up to SAT_W fits.
package amp_mod_pkg;

   typedef enum logic {
      MODE_RING = 1'b0,
      MODE_AM   = 1'b1
   } amp_mode_e;

   localparam int SAT_W = 64;

   typedef struct packed {
      logic                    sat;
      logic signed [SAT_W-1:0] value;
   } sat_result_t;

   // The caller sign-extends into SAT_W bits and keeps the low outW bits of the result.
   function automatic sat_result_t saturate(input logic signed [SAT_W-1:0] value,
                                            input int                      outW);
      logic signed [SAT_W-1:0] maxVal;
      logic signed [SAT_W-1:0] minVal;
      sat_result_t             res;
      maxVal = (64'sd1 <<< (outW - 1)) - 64'sd1;
      minVal = -maxVal - 64'sd1;
      res.sat   = 1'b1;
      res.value = value;
      if (value > maxVal) begin
         res.value = maxVal;
      end else if (value < minVal) begin
         res.value = minVal;
      end else begin
         res.sat = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/amp_mod_lane.sv
// One channel of amp_modulator_mc: optional modulator slew, product, shift/add, saturate.
// The slew limiter exists only when AMP_MOD_SLEW_EN is defined.
module amp_mod_lane
   import amp_mod_pkg::*;
#(
   parameter int DW        = 16,
   parameter int MW        = 16,
   parameter int FB        = 8,
   parameter int SLEW_STEP = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 accept_i,
   input  amp_mode_e            mode_i,
   input  logic signed [DW-1:0] signal_i,
   input  logic signed [MW-1:0] modulator_i,
   output logic signed [DW-1:0] signal_o,
   output logic                 sat_o,
   output logic                 satNext_o
);

   localparam int PW = DW + MW;
   localparam int RW = PW + 1;

   logic signed [MW-1:0] mEff;

`ifdef AMP_MOD_SLEW_EN
   localparam logic signed [MW:0] STEP_POS = (MW+1)'(SLEW_STEP);
   localparam logic signed [MW:0] STEP_NEG = -STEP_POS;

   logic signed [MW-1:0] mReg_q;
   logic signed [MW-1:0] mReg_d;
   logic signed [MW:0]   mDiff;
   logic signed [MW:0]   mStep;

   // The distance to the target is clamped so the effective gain ramps instead of jumping.
   always_comb begin
      mDiff = {modulator_i[MW-1], modulator_i} - {mReg_q[MW-1], mReg_q};
      mStep = mDiff;
      if (mDiff > STEP_POS) begin
         mStep = STEP_POS;
      end else if (mDiff < STEP_NEG) begin
         mStep = STEP_NEG;
      end
      mEff   = MW'({mReg_q[MW-1], mReg_q} + mStep);
      mReg_d = accept_i ? mEff : mReg_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mReg_q <= '0;
      end else begin
         mReg_q <= mReg_d;
      end
   end
`else
   logic unusedSlewCfg;
   assign mEff          = modulator_i;
   assign unusedSlewCfg = accept_i ^ (SLEW_STEP != 0);
`endif

   logic signed [PW-1:0] prod_d;
   logic signed [PW-1:0] prod_q;
   logic signed [RW-1:0] sigExt_d;
   logic signed [RW-1:0] sigExt_q;
   amp_mode_e            mode_q;

   assign prod_d   = signal_i * mEff;
   assign sigExt_d = RW'(signal_i);

   // Stage 1: full-width product plus the pieces stage 2 needs for AM mode.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prod_q   <= '0;
         sigExt_q <= '0;
         mode_q   <= MODE_RING;
      end else if (en_i) begin
         prod_q   <= prod_d;
         sigExt_q <= sigExt_d;
         mode_q   <= mode_i;
      end
   end

   logic signed [PW-1:0] scaled;
   logic signed [RW-1:0] sumR;
   sat_result_t          satRes;
   logic signed [DW-1:0] signal_d;

   // The extra guard bit means the AM offset addition can never wrap before the clamp.
   always_comb begin
      scaled = prod_q >>> FB;
      if (mode_q == MODE_AM) begin
         sumR = RW'(scaled) + sigExt_q;
      end else begin
         sumR = RW'(scaled);
      end
      satRes    = saturate(SAT_W'(sumR), DW);
      signal_d  = satRes.value[DW-1:0];
      satNext_o = satRes.sat;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         signal_o <= '0;
         sat_o    <= 1'b0;
      end else if (en_i) begin
         signal_o <= signal_d;
         sat_o    <= satNext_o;
      end
   end

endmodule

// File: rtl/amp_modulator_mc.sv
// N_CH-lane ring/AM modulator with a two-stage valid/ready pipeline and sticky saturation flag.
// Define AMP_MOD_SLEW_EN to rate-limit each lane's modulator by SLEW_STEP per accepted beat.
module amp_modulator_mc
   import amp_mod_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int DATA_WIDTH = 16,
   parameter int MOD_WIDTH  = 16,
   parameter int FRAC_BITS  = 8,
   parameter int SLEW_STEP  = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         mode_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [N_CH*DATA_WIDTH-1:0]   signal_i,
   input  logic [N_CH*MOD_WIDTH-1:0]    modulator_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [N_CH*DATA_WIDTH-1:0]   signal_o,
   output logic [N_CH-1:0]              sat_o,
   output logic                         sat_sticky_o,
   input  logic                         clear_sticky_i
);

   logic            v1_q;
   logic            v2_q;
   logic            satSticky_q;
   logic            satSticky_d;
   logic            en;
   logic            accept;
   logic [N_CH-1:0] satNext;

   // One enable for the whole pipe: a full output stage blocks everything behind it.
   assign en      = !v2_q || ready_i;
   assign ready_o = en && !rst_i;
   assign accept  = valid_i && ready_o;
   assign valid_o = v2_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_lane
      amp_mod_lane #(
         .DW        (DATA_WIDTH),
         .MW        (MOD_WIDTH),
         .FB        (FRAC_BITS),
         .SLEW_STEP (SLEW_STEP)
      ) u_lane (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .en_i        (en),
         .accept_i    (accept),
         .mode_i      (amp_mode_e'(mode_i)),
         .signal_i    (signal_i[k*DATA_WIDTH +: DATA_WIDTH]),
         .modulator_i (modulator_i[k*MOD_WIDTH +: MOD_WIDTH]),
         .signal_o    (signal_o[k*DATA_WIDTH +: DATA_WIDTH]),
         .sat_o       (sat_o[k]),
         .satNext_o   (satNext[k])
      );
   end

   // A fresh saturation event outranks a simultaneous clear so it is never lost.
   always_comb begin
      satSticky_d = satSticky_q;
      if (en && v1_q && (|satNext)) begin
         satSticky_d = 1'b1;
      end else if (clear_sticky_i) begin
         satSticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         satSticky_q <= 1'b0;
      end else begin
         if (en) begin
            v1_q <= valid_i;
            v2_q <= v1_q;
         end
         satSticky_q <= satSticky_d;
      end
   end

   assign sat_sticky_o = satSticky_q;

endmodule

// File: tb/tb_amp_modulator_mc.sv
// Scoreboard bench for amp_modulator_mc (default build): directed beats with hand-computed results.
module tb_amp_modulator_mc;

   localparam int N_CH = 2;
   localparam int DW   = 16;
   localparam int MW   = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 mode = 1'b0;
   logic                 validIn = 1'b0;
   logic                 readyOut;
   logic [N_CH*DW-1:0]   signalIn = '0;
   logic [N_CH*MW-1:0]   modIn = '0;
   logic                 validOut;
   logic                 readyIn = 1'b1;
   logic [N_CH*DW-1:0]   signalOut;
   logic [N_CH-1:0]      satOut;
   logic                 satSticky;
   logic                 clearSticky = 1'b0;

   typedef struct {
      int         e0;
      int         e1;
      logic [1:0] sat;
      int         acceptCyc;
      bit         chkLat;
   } exp_t;

   exp_t sb[$];
   exp_t monExp;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;

   amp_modulator_mc dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .mode_i         (mode),
      .valid_i        (validIn),
      .ready_o        (readyOut),
      .signal_i       (signalIn),
      .modulator_i    (modIn),
      .valid_o        (validOut),
      .ready_i        (readyIn),
      .signal_o       (signalOut),
      .sat_o          (satOut),
      .sat_sticky_o   (satSticky),
      .clear_sticky_i (clearSticky)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Holds the beat on the inputs until the DUT takes it, recording the expected result.
   task automatic applyStimulus(input int s0, input int m0, input int s1, input int m1,
                                input logic md, input int e0, input int e1,
                                input logic [1:0] sat, input bit lat);
      exp_t ex;
      bit   acc = 1'b0;
      int   n = 0;
      signalIn = {16'(s1), 16'(s0)};
      modIn    = {16'(m1), 16'(m0)};
      mode     = md;
      validIn  = 1'b1;
      while (!acc && n < 40) begin
         @(negedge clk);
         if (readyOut) begin
            acc          = 1'b1;
            ex.e0        = e0;
            ex.e1        = e1;
            ex.sat       = sat;
            ex.acceptCyc = cyc;
            ex.chkLat    = lat;
            sb.push_back(ex);
         end
         @(posedge clk);
         #1;
         n++;
      end
      validIn = 1'b0;
      if (!acc) checkOutput("accept timeout", 0, 1);
   endtask

   task automatic waitDrain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) checkOutput("drain timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares the head beat whenever valid_o is up; pops only on handshake.
   always @(negedge clk) begin
      if (!rst && validOut) begin
         if (sb.size() == 0) begin
            checkOutput("spurious valid_o", int'(validOut), 0);
         end else begin
            monExp = sb[0];
            checkOutput("lane0 out", int'($signed(signalOut[15:0])), monExp.e0);
            checkOutput("lane1 out", int'($signed(signalOut[31:16])), monExp.e1);
            checkOutput("sat_o", int'(satOut), int'(monExp.sat));
            if (readyIn) begin
               if (monExp.chkLat) checkOutput("latency", cyc - monExp.acceptCyc, 2);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      $display("[TB] start");
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset valid_o", int'(validOut), 0);
      checkOutput("reset signal_o", int'(signalOut), 0);
      checkOutput("reset sat_o", int'(satOut), 0);
      checkOutput("reset sticky", int'(satSticky), 0);
      checkOutput("reset ready_o", int'(readyOut), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Ring unity, ring floor rounding, AM with offset
      applyStimulus(1000, 256, 0, 0, 1'b0, 1000, 0, 2'b00, 1'b1);
      applyStimulus(-3, 128, 3, 128, 1'b0, -2, 1, 2'b00, 1'b0);
      applyStimulus(1000, -128, 1000, 256, 1'b1, 500, 2000, 2'b00, 1'b0);
      applyStimulus(1000, -256, -1000, 256, 1'b1, 0, -2000, 2'b00, 1'b0);
      waitDrain();
      @(negedge clk);
      checkOutput("sticky idle", int'(satSticky), 0);

      // Saturation, per-lane independence, sticky set and clear
      @(posedge clk);
      #1;
      applyStimulus(20000, 512, 100, 256, 1'b0, 32767, 100, 2'b01, 1'b0);
      applyStimulus(0, 0, -20000, 512, 1'b0, 0, -32768, 2'b10, 1'b0);
      applyStimulus(30000, 256, 10, 256, 1'b1, 32767, 20, 2'b01, 1'b0);
      waitDrain();
      @(negedge clk);
      checkOutput("sticky set", int'(satSticky), 1);
      @(posedge clk);
      #1;
      clearSticky = 1'b1;
      @(posedge clk);
      #1;
      clearSticky = 1'b0;
      @(negedge clk);
      checkOutput("sticky cleared", int'(satSticky), 0);

      // Clear held across the edge that loads a saturating beat: set must win
      @(posedge clk);
      #1;
      clearSticky = 1'b1;
      applyStimulus(20000, 512, 0, 0, 1'b0, 32767, 0, 2'b01, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!validOut && n < 10);
      checkOutput("sticky set beats clear", int'(satSticky), 1);
      clearSticky = 1'b0;
      @(negedge clk);
      checkOutput("sticky held", int'(satSticky), 1);
      @(posedge clk);
      #1;

      // Backpressure: six beats while ready_i drops for three cycles
      fork
         begin
            for (int k = 1; k <= 6; k++) begin
               applyStimulus(k, 256, -k, 256, 1'b0, k, -k, 2'b00, 1'b0);
            end
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            readyIn = 1'b0;
            @(negedge clk);
            checkOutput("ready_o during stall", int'(readyOut), 0);
            repeat (3) @(posedge clk);
            #1;
            readyIn = 1'b1;
         end
      join
      waitDrain();

      // Reset with two beats in flight
      applyStimulus(11, 256, 0, 0, 1'b0, 11, 0, 2'b00, 1'b0);
      applyStimulus(12, 256, 0, 0, 1'b0, 12, 0, 2'b00, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("valid_o after reset edge", int'(validOut), 0);
      checkOutput("sticky after reset", int'(satSticky), 0);
      sb.delete();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("no stale beat", int'(validOut), 0);
      end
      @(posedge clk);
      #1;
      applyStimulus(7, 256, -7, 512, 1'b0, 7, -14, 2'b00, 1'b1);
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
